// File: rtl/kamacore_pkg.sv
// Shared kamacore definitions: datapath widths and the memory-port owner tag.
package kamacore_pkg;

  localparam int CPU_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;

  // Which requester a pending memory read belongs to.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/kamacore_mem_arbiter.sv
// Arbiter for a shared single-port memory between instruction fetch and the
// data side. Data normally wins. Fetch is forced through after STARVE_LIMIT
// consecutive data grants while it waits. Reads return one cycle after the grant.
module kamacore_mem_arbiter
  import kamacore_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch side
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  input  logic                  if_kill,
  output logic                  if_rsp_valid,
  output logic [CPU_WIDTH-1:0]  if_rsp_data,
  // data side
  input  logic                  dm_req_valid,
  input  logic                  dm_req_we,
  input  logic [ADDR_WIDTH-1:0] dm_req_addr,
  input  logic [CPU_WIDTH-1:0]  dm_req_wdata,
  output logic                  dm_req_ready,
  output logic                  dm_rsp_valid,
  output logic [CPU_WIDTH-1:0]  dm_rsp_data,
  // shared memory port
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [CPU_WIDTH-1:0]  mem_di,
  input  logic [CPU_WIDTH-1:0]  mem_do
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             pend_valid;
  owner_e           pend_owner;

  logic fetch_forced;
  logic grant_if;
  logic grant_dm;

  // Pick at most one requester this cycle; a kill always blocks the fetch grant.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    grant_if     = 1'b0;
    grant_dm     = 1'b0;
    fetch_forced = if_req_valid && !if_kill && (starve_cnt == CNT_MAX);
    if (!rst) begin
      if (fetch_forced) begin
        grant_if = 1'b1;
      end else if (dm_req_valid) begin
        grant_dm = 1'b1;
      end else if (if_req_valid && !if_kill) begin
        grant_if = 1'b1;
      end
    end
  end

  // Drive the memory command from whichever side won; idle port is all zeros.
  always_comb begin
    if_req_ready = grant_if;
    dm_req_ready = grant_dm;
    mem_we       = 1'b0;
    mem_a        = '0;
    mem_di       = '0;
    if (grant_dm) begin
      mem_we = dm_req_we;
      mem_a  = dm_req_addr;
      mem_di = dm_req_wdata;
    end else if (grant_if) begin
      mem_a  = if_req_addr;
    end
  end

  // Count data grants made while fetch waits; saturate at the limit.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Tag the read issued this cycle so its data is routed next cycle; writes get no tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_owner <= OWN_IF;
    end else begin
      pend_valid <= grant_if || (grant_dm && !dm_req_we);
      pend_owner <= grant_dm ? OWN_DM : OWN_IF;
    end
  end

  // Route registered memory data to the owner; a kill squashes only the fetch response.
  always_comb begin
    if_rsp_valid = !rst && pend_valid && (pend_owner == OWN_IF) && !if_kill;
    dm_rsp_valid = !rst && pend_valid && (pend_owner == OWN_DM);
    if_rsp_data  = if_rsp_valid ? mem_do : '0;
    dm_rsp_data  = dm_rsp_valid ? mem_do : '0;
  end

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Directed bench for kamacore_mem_arbiter with a registered 16-word memory model.
module tb_kamacore_mem_arbiter;
  import kamacore_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_req_ready;
  logic                  if_kill;
  logic                  if_rsp_valid;
  logic [CPU_WIDTH-1:0]  if_rsp_data;
  logic                  dm_req_valid;
  logic                  dm_req_we;
  logic [ADDR_WIDTH-1:0] dm_req_addr;
  logic [CPU_WIDTH-1:0]  dm_req_wdata;
  logic                  dm_req_ready;
  logic                  dm_rsp_valid;
  logic [CPU_WIDTH-1:0]  dm_rsp_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [CPU_WIDTH-1:0]  mem_di;
  logic [CPU_WIDTH-1:0]  mem_do;

  logic [CPU_WIDTH-1:0]  mem [0:15];

  int checks = 0;
  int errors = 0;

  kamacore_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_kill      (if_kill),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .dm_req_valid (dm_req_valid),
    .dm_req_we    (dm_req_we),
    .dm_req_addr  (dm_req_addr),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_ready (dm_req_ready),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_data  (dm_rsp_data),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_di       (mem_di),
    .mem_do       (mem_do)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[3:0]] <= mem_di;
    mem_do <= mem[mem_a[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ifv, input logic [ADDR_WIDTH-1:0] ifa, input logic kill,
                       input logic dv, input logic we, input logic [ADDR_WIDTH-1:0] da,
                       input logic [CPU_WIDTH-1:0] wd);
    if_req_valid = ifv;
    if_req_addr  = ifa;
    if_kill      = kill;
    dm_req_valid = dv;
    dm_req_we    = we;
    dm_req_addr  = da;
    dm_req_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Move to the cycle after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] fetch_pat;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
    mem_do = '0;

    // ---- reset: requests present but everything must stay quiet
    rst = 1'b1;
    drive(1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 16'd4, 32'hFF);
    @(negedge clk);
    check("rst_if_ready", {31'b0, if_req_ready}, 0);
    check("rst_dm_ready", {31'b0, dm_req_ready}, 0);
    check("rst_mem_we",   {31'b0, mem_we}, 0);
    check("rst_mem_a",    {16'b0, mem_a}, 0);
    check("rst_mem_di",   mem_di, 0);
    next();
    @(negedge clk);
    check("rst_starve",   {29'b0, dut.starve_cnt}, 0);
    check("rst_if_rsp",   {31'b0, if_rsp_valid}, 0);
    check("rst_dm_rsp",   {31'b0, dm_rsp_valid}, 0);
    check("rst_rsp_data", if_rsp_data | dm_rsp_data, 0);
    next();
    rst = 1'b0;
    idle();
    next();

    // ---- fetch-only stream, addresses 0,1,2
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, ADDR_WIDTH'(i), 1'b0, 1'b0, 1'b0, '0, '0);
      else idle();
      @(negedge clk);
      if (i < 3) begin
        check($sformatf("fetch_ready_%0d", i), {31'b0, if_req_ready}, 1);
        check($sformatf("fetch_mem_a_%0d", i), {16'b0, mem_a}, i);
        check($sformatf("fetch_mem_we_%0d", i), {31'b0, mem_we}, 0);
      end
      check($sformatf("fetch_rsp_v_%0d", i), {31'b0, if_rsp_valid}, (i >= 1 && i <= 3) ? 1 : 0);
      check($sformatf("fetch_rsp_d_%0d", i), if_rsp_data, (i >= 1 && i <= 3) ? 32'h1000 + i - 1 : 0);
      next();
    end

    // ---- data write 0xA5 to addr 5, then read it back
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 16'd5, 32'hA5);
    @(negedge clk);
    check("wr_ready",  {31'b0, dm_req_ready}, 1);
    check("wr_mem_we", {31'b0, mem_we}, 1);
    check("wr_mem_a",  {16'b0, mem_a}, 5);
    check("wr_mem_di", mem_di, 32'hA5);
    next();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 16'd5, 32'h0);
    @(negedge clk);
    check("rd_ready",      {31'b0, dm_req_ready}, 1);
    check("rd_mem_we",     {31'b0, mem_we}, 0);
    check("wr_no_rsp",     {31'b0, dm_rsp_valid}, 0);
    next();
    idle();
    @(negedge clk);
    check("rd_rsp_valid",  {31'b0, dm_rsp_valid}, 1);
    check("rd_rsp_data",   dm_rsp_data, 32'hA5);
    check("rd_if_quiet",   {31'b0, if_rsp_valid}, 0);
    next();
    idle();
    @(negedge clk);
    check("rd_rsp_done",   {31'b0, dm_rsp_valid}, 0);
    next();

    // ---- both requesters held: D,D,D,D,F,D,D,D,D,F
    fetch_pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'd7, 1'b0, 1'b1, 1'b0, 16'd9, '0);
      @(negedge clk);
      check($sformatf("starve_cnt_%0d", i), {29'b0, dut.starve_cnt}, i % 5);
      check($sformatf("pat_if_ready_%0d", i), {31'b0, if_req_ready}, {31'b0, fetch_pat[i]});
      check($sformatf("pat_dm_ready_%0d", i), {31'b0, dm_req_ready}, {31'b0, !fetch_pat[i]});
      if (i > 0) begin
        check($sformatf("pat_if_rsp_%0d", i), if_rsp_data, fetch_pat[i-1] ? 32'h1007 : 32'h0);
        check($sformatf("pat_dm_rsp_%0d", i), dm_rsp_data, fetch_pat[i-1] ? 32'h0 : 32'h1009);
      end
      next();
    end
    idle();
    @(negedge clk);
    check("pat_last_if_rsp", if_rsp_data, 32'h1007);
    next();
    @(negedge clk);
    check("starve_cleared", {29'b0, dut.starve_cnt}, 0);
    next();

    // ---- kill holds fetch off; counter saturates at the limit
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'd8, 1'b1, 1'b1, 1'b0, 16'd9, '0);
      @(negedge clk);
      check($sformatf("kill_if_ready_%0d", i), {31'b0, if_req_ready}, 0);
      check($sformatf("kill_dm_ready_%0d", i), {31'b0, dm_req_ready}, 1);
      if (i > 0) check($sformatf("kill_dm_rsp_%0d", i), dm_rsp_data, 32'h1009);
      check($sformatf("sat_cnt_%0d", i), {29'b0, dut.starve_cnt}, (i < 4) ? i : 4);
      next();
    end
    drive(1'b1, 16'd8, 1'b0, 1'b1, 1'b0, 16'd9, '0);
    @(negedge clk);
    check("sat_forced_fetch", {31'b0, if_req_ready}, 1);
    check("sat_forced_mem_a", {16'b0, mem_a}, 8);
    next();
    idle();
    @(negedge clk);
    check("sat_fetch_rsp", if_rsp_data, 32'h1008);
    next();

    // ---- kill in the response cycle squashes the fetch response
    drive(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("killrsp_grant", {31'b0, if_req_ready}, 1);
    next();
    drive(1'b1, 16'd3, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("killrsp_ready", {31'b0, if_req_ready}, 0);
    check("killrsp_valid", {31'b0, if_rsp_valid}, 0);
    check("killrsp_data",  if_rsp_data, 0);
    check("killrsp_mem_a", {16'b0, mem_a}, 0);
    next();
    idle();
    @(negedge clk);
    check("killrsp_after", {31'b0, if_rsp_valid}, 0);
    next();

    // ---- kill does not touch a data response
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 16'd5, '0);
    next();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("kill_dm_valid", {31'b0, dm_rsp_valid}, 1);
    check("kill_dm_data",  dm_rsp_data, 32'hA5);
    next();

    // ---- reset with a fetch read in flight
    drive(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rstfl_grant", {31'b0, if_req_ready}, 1);
    next();
    rst = 1'b1;
    drive(1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd2, '0);
    @(negedge clk);
    check("rstfl_if_rsp",   {31'b0, if_rsp_valid}, 0);
    check("rstfl_if_data",  if_rsp_data, 0);
    check("rstfl_ready",    {30'b0, if_req_ready, dm_req_ready}, 0);
    check("rstfl_mem_a",    {16'b0, mem_a}, 0);
    next();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("rstfl_no_if_rsp", {31'b0, if_rsp_valid}, 0);
    check("rstfl_no_dm_rsp", {31'b0, dm_rsp_valid}, 0);
    next();
    drive(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rstfl_refetch", {31'b0, if_req_ready}, 1);
    next();
    idle();
    @(negedge clk);
    check("rstfl_refetch_v", {31'b0, if_rsp_valid}, 1);
    check("rstfl_refetch_d", if_rsp_data, 32'h1001);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kamacore_mem_arbiter.md
KAMACORE_MEM_ARBITER -- requirements
Module: kamacore_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data-side grants while a fetch request waits.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req_valid  in  1  fetch requests a read.
REQ-005 if_req_addr  in  ADDR_WIDTH  fetch address.
REQ-006 if_req_ready  out  1  fetch request granted this cycle.
REQ-007 if_kill  in  1  branch redirect; discards the in-flight fetch and blocks the fetch grant this cycle.
REQ-008 if_rsp_valid  out  1  fetch read data valid.
REQ-009 if_rsp_data  out  CPU_WIDTH  fetch read data.
REQ-010 dm_req_valid  in  1  data-side access request.
REQ-011 dm_req_we  in  1  1 = write, 0 = read.
REQ-012 dm_req_addr  in  ADDR_WIDTH  data address.
REQ-013 dm_req_wdata  in  CPU_WIDTH  write data.
REQ-014 dm_req_ready  out  1  data request granted this cycle.
REQ-015 dm_rsp_valid  out  1  data read data valid.
REQ-016 dm_rsp_data  out  CPU_WIDTH  data read data.
REQ-017 mem_we / mem_a / mem_di  out  1 / ADDR_WIDTH / CPU_WIDTH  shared single-port memory command.
REQ-018 mem_do  in  CPU_WIDTH  memory read data, registered; valid one cycle after the command.

Function
REQ-019 One grant per cycle at most; handshake = valid && ready; the requester SHALL hold valid, addr, we and wdata stable until ready.
REQ-020 Default priority: data wins when dm_req_valid is high.
REQ-021 Fetch wins instead when if_req_valid && !if_kill && starve_cnt == STARVE_LIMIT.
REQ-022 if_req_ready = 0 whenever if_kill = 1.
REQ-023 Granted fetch: mem_a = if_req_addr, mem_we = 0.
REQ-024 Granted data: mem_a = dm_req_addr, mem_we = dm_req_we, mem_di = dm_req_wdata.
REQ-025 No grant: mem_we = 0, mem_a = 0, mem_di = 0.
REQ-026 starve_cnt (clog2(STARVE_LIMIT+1) bits):
  - increments on a data grant while if_req_valid is high;
  - clears on a fetch grant or when if_req_valid is low;
  - saturates at STARVE_LIMIT, never wraps.
REQ-027 In-flight tag register {pend_valid, pend_owner} SHALL be set for each granted read and cleared otherwise; writes produce no response.
REQ-028 Read latency is exactly 1: rsp_valid for the owner is asserted in the cycle after the grant; rsp_data = mem_do then, 0 otherwise.
REQ-029 Full throughput: back-to-back grants SHALL produce back-to-back responses with no bubble.
REQ-030 if_kill high in the response cycle forces if_rsp_valid = 0 and if_rsp_data = 0 for that cycle; data responses are unaffected.
REQ-031 Simultaneous dm grant and pending fetch response SHALL both complete in the same cycle; the response path is independent of the grant path.

Reset
REQ-032 While rst = 1:
  - all ready, rsp_valid and mem_we outputs are 0;
  - rsp_data, mem_a and mem_di are 0;
  - starve_cnt and pend_valid are cleared.
REQ-033 Reset asserted with a read in flight discards that read: no rsp_valid is asserted in the cycle after rst deasserts.

Structure
REQ-034 CPU_WIDTH, ADDR_WIDTH and the owner enum (OWN_IF, OWN_DM) SHALL live in the shared kamacore package; STARVE_LIMIT stays a module parameter.
REQ-035 Single module, no sub-modules; grant logic is combinational, and starve_cnt and the pending tag are the only state.

Verification
REQ-036 Fetch only, addr 0,1,2 on consecutive cycles -> if_req_ready 1 each cycle; if_rsp_valid 1 on cycles +1..+3 with mem[0..2], in order.
REQ-037 Both requesters held valid continuously, STARVE_LIMIT = 4 -> grant pattern D,D,D,D,F repeating; starve_cnt never exceeds 4.
REQ-038 Data write addr 5 data 0xA5, then data read addr 5 -> dm_rsp_valid only for the read, dm_rsp_data = 0xA5, no response for the write.
REQ-039 Fetch granted at cycle N, if_kill = 1 at N+1 -> if_rsp_valid 0 at N+1 and if_req_ready 0 at N+1.
REQ-040 Read granted, rst = 1 on the next cycle for 1 cycle -> all outputs 0 during rst, no rsp_valid after release; the next fetch completes normally.
